// File: rtl/pong_ball_if.sv
// Ball engine bus: speed/serve controls and paddle positions in,
// ball position, round reset and scores out.
interface pong_ball_if;
    logic       s;
    logic       start;
    logic [9:0] pad0_x;
    logic [9:0] pad0_y;
    logic [9:0] pad1_x;
    logic [9:0] pad1_y;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       guiwei;
    logic [3:0] score0;
    logic [3:0] score1;
    logic       game_over;

    modport master (
        input  s, start, pad0_x, pad0_y, pad1_x, pad1_y,
        output ball_x, ball_y, guiwei, score0, score1, game_over
    );

    modport slave (
        output s, start, pad0_x, pad0_y, pad1_x, pad1_y,
        input  ball_x, ball_y, guiwei, score0, score1, game_over
    );
endinterface

// File: rtl/pong_ball.sv
// Pong ball engine: motion, wall/paddle bounces, misses, scoring and
// serve / round-end / game-over sequencing.
module pong_ball #(
    parameter int H_DISP     = 640,
    parameter int V_DISP     = 480,
    parameter int SLDE_W     = 10,
    parameter int BALL_W     = 10,
    parameter int PAD_W      = 10,
    parameter int PAD_L      = 80,
    parameter int X0         = 316,
    parameter int Y0         = 236,
    parameter int SPEED_FAST = 80000,
    parameter int SPEED_SLOW = 190000,
    parameter int HOLD_TICKS = 60,
    parameter int WIN_SCORE  = 9
) (
    input logic         vga_clk,
    input logic         sys_rst_n,
    pong_ball_if.master bus
);
    localparam int SPD_MAX = (SPEED_SLOW > SPEED_FAST) ? SPEED_SLOW
                                                       : SPEED_FAST;
    localparam int CW = $clog2(SPD_MAX) + 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);

    localparam logic [10:0] TOP_Y   = 11'(SLDE_W);
    localparam logic [10:0] BOT_Y   = 11'(V_DISP - SLDE_W - BALL_W);
    localparam logic [10:0] LEFT_X  = 11'(SLDE_W);
    localparam logic [10:0] RIGHT_X = 11'(H_DISP - SLDE_W - BALL_W);

    typedef enum logic [1:0] {SERVE, PLAY, SCORED, OVER} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] speed_m1;
    logic          tick;
    logic [HW-1:0] hold;
    logic          start_d;
    logic          start_re;
    logic [9:0]    x_q;
    logic [9:0]    y_q;
    logic          dx;
    logic          dy;
    logic          guiwei_q;
    logic          over_q;
    logic [3:0]    sc0;
    logic [3:0]    sc1;

    logic [10:0] bx, by, p0x, p0y, p1x, p1y;
    logic        ov0, ov1, hit0, hit1;
    logic        miss0, miss1, at_top, at_bot;

    assign speed_m1 = bus.s ? CW'(SPEED_FAST - 1) : CW'(SPEED_SLOW - 1);
    assign tick     = (cnt >= speed_m1);

    assign bx  = {1'b0, x_q};
    assign by  = {1'b0, y_q};
    assign p0x = {1'b0, bus.pad0_x};
    assign p0y = {1'b0, bus.pad0_y};
    assign p1x = {1'b0, bus.pad1_x};
    assign p1y = {1'b0, bus.pad1_y};

    // Window bounds rearranged so no term is ever subtracted below zero.
    assign ov0  = (by + 11'(BALL_W) > p0y) && (by < p0y + 11'(PAD_L));
    assign ov1  = (by + 11'(BALL_W) > p1y) && (by < p1y + 11'(PAD_L));
    assign hit0 = (bx + 11'd1 >= p0x + 11'(PAD_W))
               && (bx <= p0x + 11'(PAD_W + 1)) && ov0;
    assign hit1 = (bx + 11'(BALL_W + 1) >= p1x)
               && (bx + 11'(BALL_W) <= p1x + 11'd1) && ov1;

    assign miss0  = (bx <= LEFT_X);
    assign miss1  = (bx >= RIGHT_X);
    assign at_top = (by <= TOP_Y);
    assign at_bot = (by >= BOT_Y);

    assign bus.ball_x    = x_q;
    assign bus.ball_y    = y_q;
    assign bus.guiwei    = guiwei_q;
    assign bus.score0    = sc0;
    assign bus.score1    = sc1;
    assign bus.game_over = over_q;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= SERVE;
            cnt      <= '0;
            hold     <= '0;
            start_d  <= 1'b0;
            start_re <= 1'b0;
            x_q      <= 10'(X0);
            y_q      <= 10'(Y0);
            dx       <= 1'b1;
            dy       <= 1'b1;
            guiwei_q <= 1'b0;
            over_q   <= 1'b0;
            sc0      <= '0;
            sc1      <= '0;
        end else begin
            cnt      <= tick ? '0 : cnt + 1'b1;
            start_d  <= bus.start;
            start_re <= bus.start & ~start_d;
            unique case (state)
                SERVE: begin
                    x_q      <= 10'(X0);
                    y_q      <= 10'(Y0);
                    guiwei_q <= 1'b0;
                    if (start_re) state <= PLAY;
                end
                PLAY: if (tick) begin
                    if (!dy && at_top)     dy  <= 1'b1;
                    else if (dy && at_bot) dy  <= 1'b0;
                    else if (dy)           y_q <= y_q + 10'd2;
                    else                   y_q <= y_q - 10'd2;
                    // The later assignments on a miss override the move.
                    if (!dx) begin
                        if (hit0) dx <= 1'b1;
                        else if (miss0) begin
                            sc1      <= sc1 + 4'd1;
                            x_q      <= 10'(X0);
                            y_q      <= 10'(Y0);
                            dx       <= 1'b1;
                            dy       <= ~dy;
                            guiwei_q <= 1'b1;
                            hold     <= '0;
                            state    <= SCORED;
                        end else x_q <= x_q - 10'd2;
                    end else begin
                        if (hit1) dx <= 1'b0;
                        else if (miss1) begin
                            sc0      <= sc0 + 4'd1;
                            x_q      <= 10'(X0);
                            y_q      <= 10'(Y0);
                            dx       <= 1'b0;
                            dy       <= ~dy;
                            guiwei_q <= 1'b1;
                            hold     <= '0;
                            state    <= SCORED;
                        end else x_q <= x_q + 10'd2;
                    end
                end
                SCORED: if (tick) begin
                    if (hold == HW'(HOLD_TICKS - 1)) begin
                        hold <= '0;
                        if (sc0 == 4'(WIN_SCORE) || sc1 == 4'(WIN_SCORE)) begin
                            over_q <= 1'b1;
                            state  <= OVER;
                        end else begin
                            guiwei_q <= 1'b0;
                            state    <= SERVE;
                        end
                    end else hold <= hold + 1'b1;
                end
                OVER: if (start_re) begin
                    sc0      <= '0;
                    sc1      <= '0;
                    dx       <= 1'b1;
                    dy       <= 1'b1;
                    guiwei_q <= 1'b0;
                    over_q   <= 1'b0;
                    state    <= SERVE;
                end
            endcase
        end
    end
endmodule
